// File: rtl/alu_pkg.sv
// Shared widths, command type and op encodings for the alu front end.
package alu_pkg;

  localparam int srcwidth = 8;
  localparam int dstwidth = 16;

  localparam logic [2:0] OP_MEAN = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;

  typedef struct packed {
    logic       vld;
    logic [2:0] op;
  } alu_cmd_t;

  typedef struct packed {
    logic                vld;
    logic [dstwidth-1:0] data;
  } uint_vld_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op inside {OP_MEAN, OP_MUL, OP_DIV, OP_ADD, OP_SUB};
  endfunction

endpackage

// File: rtl/alu_issuer_if.sv
// Request and response handshake bundle of the alu issuer.
interface alu_issuer_if #(
  parameter int SRCW = alu_pkg::srcwidth,
  parameter int DSTW = alu_pkg::dstwidth,
  parameter int TAGW = 2
);

  logic            req_vld;
  logic            req_rdy;
  logic [2:0]      req_op;
  logic [SRCW-1:0] req_a;
  logic [SRCW-1:0] req_b;
  logic [TAGW-1:0] req_tag;

  logic            rsp_vld;
  logic            rsp_rdy;
  logic [DSTW-1:0] rsp_data;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_err;

  modport master (
    output req_vld, req_op, req_a, req_b, req_tag, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_data, rsp_tag, rsp_err
  );

  modport slave (
    input  req_vld, req_op, req_a, req_b, req_tag, rsp_rdy,
    output req_rdy, rsp_vld, rsp_data, rsp_tag, rsp_err
  );

endinterface

// File: rtl/alu_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one wrap bit to tell full from empty.
module alu_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero when empty so stale storage never leaks after reset.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_issuer.sv
// Queues tagged requests, issues one alu beat per cycle under a credit limit,
// and returns results in order through a response FIFO.
module alu_issuer
  import alu_pkg::*;
#(
  parameter int SRCW      = srcwidth,
  parameter int DSTW      = dstwidth,
  parameter int TAGW      = 2,
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  alu_issuer_if.slave     bus,
  output alu_cmd_t        alu_cmd,
  output logic [SRCW-1:0] operand_a,
  output logic [SRCW-1:0] operand_b,
  input  logic [DSTW-1:0] result
);

  localparam int REQW = 3 + 2*SRCW + TAGW;
  localparam int RSPW = DSTW + TAGW + 1;
  localparam int CW   = $clog2(RSP_DEPTH) + 1;

  typedef struct packed {
    logic            vld;
    logic            err;
    logic [TAGW-1:0] tag;
  } pipe_t;

  logic [REQW-1:0] req_din;
  logic [REQW-1:0] req_dout;
  logic            req_full;
  logic            req_empty;
  logic [2:0]      head_op;
  logic [SRCW-1:0] head_a;
  logic [SRCW-1:0] head_b;
  logic [TAGW-1:0] head_tag;
  logic            head_err;
  logic            issue;
  logic [CW-1:0]   cnt;
  pipe_t           pipe [ALU_LAT+1];
  logic            rsp_push;
  logic            rsp_pop;
  logic            rsp_full;
  logic            rsp_empty;
  logic [DSTW-1:0] rsp_result;
  logic [RSPW-1:0] rsp_din;
  logic [RSPW-1:0] rsp_dout;

  assign req_din     = {bus.req_op, bus.req_a, bus.req_b, bus.req_tag};
  assign bus.req_rdy = !req_full;

  alu_fifo #(.W(REQW), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk   (clk),
    .rst   (reset_n),
    .push  (bus.req_vld),
    .din   (req_din),
    .pop   (issue),
    .dout  (req_dout),
    .full  (req_full),
    .empty (req_empty)
  );

  assign {head_op, head_a, head_b, head_tag} = req_dout;
  assign head_err = !is_legal_op(head_op) || (head_op == OP_DIV && head_b == '0);
  assign issue    = !req_empty && (cnt < CW'(RSP_DEPTH));

  // Error ops still take a credit and a pipe slot so responses stay in order.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      alu_cmd   <= '0;
      operand_a <= '0;
      operand_b <= '0;
    end else if (issue && !head_err) begin
      alu_cmd   <= '{vld: 1'b1, op: head_op};
      operand_a <= head_a;
      operand_b <= head_b;
    end else begin
      alu_cmd   <= '0;
      operand_a <= '0;
      operand_b <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int i = 0; i <= ALU_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{vld: issue, err: head_err, tag: head_tag};
      for (int i = 1; i <= ALU_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rsp_push   = pipe[ALU_LAT].vld;
  assign rsp_result = pipe[ALU_LAT].err ? '0 : result;
  assign rsp_din    = {rsp_result, pipe[ALU_LAT].tag, pipe[ALU_LAT].err};
  assign rsp_pop    = bus.rsp_rdy && !rsp_empty;

  alu_fifo #(.W(RSPW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk   (clk),
    .rst   (reset_n),
    .push  (rsp_push),
    .din   (rsp_din),
    .pop   (bus.rsp_rdy),
    .dout  (rsp_dout),
    .full  (rsp_full),
    .empty (rsp_empty)
  );

  assign bus.rsp_vld = !rsp_empty;
  assign {bus.rsp_data, bus.rsp_tag, bus.rsp_err} = rsp_dout;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      cnt <= '0;
    end else if (issue && !rsp_pop) begin
      cnt <= cnt + CW'(1);
    end else if (!issue && rsp_pop) begin
      cnt <= cnt - CW'(1);
    end
  end

  a_rsp_push_full: assert property (@(posedge clk) disable iff (reset_n) !(rsp_push && rsp_full))
    else $error("rsp push while full");

endmodule
